less_than: RTL and testbench
============================

LESS_THAN -- requirements
Module: less_than

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal values 2..64.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  qualifies sr/tg for capture on this clk edge.
REQ-005 sr  input  WIDTH  source operand (left-hand side of the compare).
REQ-006 tg  input  WIDTH  target operand (right-hand side of the compare).
REQ-007 out_valid  output  1  lt/ltu/eq hold a valid result.
REQ-008 lt  output  1  1 when sr < tg as two's-complement signed values.
REQ-009 ltu  output  1  1 when sr < tg as unsigned values.
REQ-010 eq  output  1  1 when sr == tg bit-for-bit.

Function
REQ-011 Outputs are registered; latency is exactly 1 clk from an in_valid=1 edge to out_valid=1 with the matching result.
REQ-012 On an edge with in_valid=1: out_valid<=1 and lt/ltu/eq <= the compare of sr,tg sampled at that edge.
REQ-013 On an edge with in_valid=0: out_valid<=0; lt/ltu/eq hold their previous values.
REQ-014 Back-to-back in_valid=1 on consecutive edges yields one result per cycle, with no bubbles.
REQ-015 No back-pressure; a result is presented for one cycle and is not stalled.
REQ-016 ltu is the unsigned magnitude compare over all WIDTH bits.
REQ-017 lt = sr[MSB] when sr[MSB] != tg[MSB]; otherwise lt = ltu.
REQ-018 eq=1 implies lt=0 and ltu=0; at most one of {ltu, eq, unsigned-greater} holds.
REQ-019 Boundaries:
- all-ones vs zero: lt=1, ltu=0.
- most-negative vs most-positive: lt=1, ltu=0.
- equal operands: lt=0, ltu=0, eq=1.
REQ-020 X-free: the outputs depend only on registered state, never combinationally on the inputs.

Reset
REQ-021 While rst=1, out_valid, lt, ltu and eq are 0, asynchronously and independent of clk.
REQ-022 A reset asserted with a result in flight discards that result.
REQ-023 The first capture occurs on the first rising clk edge with rst=0 and in_valid=1.

Structure
REQ-024 A shared package holds the WIDTH default constant and a result struct/bundle {lt, ltu, eq}.
REQ-025 Sub-module ult_cmp: combinational unsigned comparator returning {ltu, eq}.
- Built as a tree of 4-bit slice compares merged MSB-first.
- The generic relational operator is not used for the core.
REQ-026 The top instantiates one ult_cmp, derives lt per REQ-017, and registers the outputs.

Verification
REQ-027 sr=5, tg=5 -> next cycle lt=0, ltu=0, eq=1, out_valid=1.
REQ-028 sr=3, tg=7 -> lt=1, ltu=1, eq=0; sr=8, tg=4 -> lt=0, ltu=0, eq=0.
REQ-029 Sign cases:
- sr=0xFFFFFFFE, tg=3 -> lt=1, ltu=0, eq=0.
- sr=2, tg=0xFFFFFFFD -> lt=0, ltu=1, eq=0.
REQ-030 Extremes:
- sr=0xFFFFFFFF, tg=0 -> lt=1, ltu=0.
- sr=0x80000000, tg=0x7FFFFFFF -> lt=1, ltu=0.
REQ-031 Streaming, reset, idle:
- Stream the 6 vectors above on consecutive cycles -> 6 consecutive matching results.
- Assert rst mid-stream -> all outputs 0 immediately.
- in_valid=0 -> out_valid=0 and lt/ltu/eq held.
REQ-032 Random 10k vectors at WIDTH=32 and WIDTH=8 checked against the language's signed/unsigned compare.

Source files
------------

// File: rtl/less_than_pkg.sv
`default_nettype none
// ============================================================================
// Module      : less_than_pkg
// Description : Shared definitions for the less_than comparator slice:
//               default operand width, the registered result bundle and the
//               merge step used to combine per-slice compare results.
// Revision    : 1.0  initial release
// ============================================================================
package less_than_pkg;

    localparam int unsigned c_default_width = 32;

    // Registered result bundle presented on the lt/ltu/eq outputs.
    typedef struct packed {
        logic lt;
        logic ltu;
        logic eq;
    } cmp_result_t;

    // Combine the compare of a more-significant chunk (hi) with the compare
    // of the adjacent less-significant chunk (lo). The high chunk decides
    // unless it is equal, in which case the low chunk decides.
    // Returns {ltu, eq} for the concatenated chunk.
    function automatic logic [1:0] cmp_merge(input logic hi_lt, input logic hi_eq,
                                             input logic lo_lt, input logic lo_eq);
        return {hi_lt | (hi_eq & lo_lt), hi_eq & lo_eq};
    endfunction

endpackage : less_than_pkg
`default_nettype wire

// File: rtl/less_than_ult_cmp.sv
`default_nettype none
// ============================================================================
// Module      : ult_cmp
// Description : Combinational unsigned magnitude comparator. Operands are cut
//               into 4-bit slices, each slice is compared via the borrow out
//               of a 5-bit subtraction, and slice results are merged through a
//               balanced binary tree with the more-significant side winning.
// Ports       : a    [WIDTH-1:0] in   left-hand operand
//               b    [WIDTH-1:0] in   right-hand operand
//               ltu              out  a < b (unsigned)
//               eq               out  a == b
// Revision    : 1.0  initial release
// ============================================================================
module ult_cmp
    import less_than_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ltu,
    output logic             eq
);

    localparam int NSL   = (WIDTH + 3) / 4;         // real 4-bit slices
    localparam int PW    = NSL * 4;                 // padded operand width
    localparam int NLEAF = 1 << $clog2(NSL);        // tree leaves (power of 2)
    localparam int NNODE = 2 * NLEAF - 1;           // heap-ordered tree nodes

    logic [PW-1:0]    w_a;
    logic [PW-1:0]    w_b;
    logic [NNODE-1:0] w_node_lt;
    logic [NNODE-1:0] w_node_eq;

    // Zero-extend to a whole number of slices; equal padding never changes
    // the outcome.
    always_comb begin
        w_a            = '0;
        w_b            = '0;
        w_a[WIDTH-1:0] = a;
        w_b[WIDTH-1:0] = b;
    end

    // Leaves: leaf j sits at heap index NLEAF-1+j and covers slice j
    // (slice 0 = least significant). Leaves beyond the operand are neutral.
    for (genvar j = 0; j < NLEAF; j++) begin : g_leaf
        if (j < NSL) begin : g_real
            logic [4:0] w_diff;
            // Borrow out of the zero-extended subtraction is the unsigned
            // less-than of the slice.
            assign w_diff                = {1'b0, w_a[4*j +: 4]} - {1'b0, w_b[4*j +: 4]};
            assign w_node_lt[NLEAF-1+j]  = w_diff[4];
            assign w_node_eq[NLEAF-1+j]  = (w_a[4*j +: 4] == w_b[4*j +: 4]);
        end else begin : g_pad
            assign w_node_lt[NLEAF-1+j]  = 1'b0;
            assign w_node_eq[NLEAF-1+j]  = 1'b1;
        end
    end

    // Internal nodes: left child (2k+1) holds the lower slices, right child
    // (2k+2) the higher ones.
    for (genvar k = 0; k < NLEAF - 1; k++) begin : g_node
        assign {w_node_lt[k], w_node_eq[k]} = cmp_merge(w_node_lt[2*k+2], w_node_eq[2*k+2],
                                                        w_node_lt[2*k+1], w_node_eq[2*k+1]);
    end

    assign ltu = w_node_lt[0];
    assign eq  = w_node_eq[0];

endmodule : ult_cmp
`default_nettype wire

// File: rtl/less_than.sv
`default_nettype none
// ============================================================================
// Module      : less_than
// Description : Registered signed/unsigned/equality compare of two operands,
//               one-cycle latency, one result per cycle, no back-pressure.
// Ports       : clk               in   rising-edge clock
//               rst               in   asynchronous active-high reset
//               in_valid          in   capture sr/tg on this edge
//               sr    [WIDTH-1:0] in   left-hand operand
//               tg    [WIDTH-1:0] in   right-hand operand
//               out_valid         out  lt/ltu/eq hold a fresh result
//               lt                out  sr < tg (two's complement)
//               ltu               out  sr < tg (unsigned)
//               eq                out  sr == tg
// Revision    : 1.0  initial release
// ============================================================================
module less_than
    import less_than_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] sr,
    input  logic [WIDTH-1:0] tg,
    output logic             out_valid,
    output logic             lt,
    output logic             ltu,
    output logic             eq
);

    logic        w_ltu;
    logic        w_eq;
    logic        w_lt;
    cmp_result_t r_res;
    logic        r_out_valid;

    ult_cmp #(
        .WIDTH (WIDTH)
    ) u_ult_cmp (
        .a   (sr),
        .b   (tg),
        .ltu (w_ltu),
        .eq  (w_eq)
    );

    // Differing sign bits: the operand with the sign bit set is the negative
    // one, so it is the smaller. Same sign bits: signed order equals
    // unsigned order.
    assign w_lt = (sr[WIDTH-1] != tg[WIDTH-1]) ? sr[WIDTH-1] : w_ltu;

    // Result fields update only on a capture; out_valid is a one-cycle pulse
    // per captured pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_res       <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_res.lt  <= w_lt;
                r_res.ltu <= w_ltu;
                r_res.eq  <= w_eq;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign lt        = r_res.lt;
    assign ltu       = r_res.ltu;
    assign eq        = r_res.eq;

endmodule : less_than
`default_nettype wire

// File: tb/tb_less_than.sv
`default_nettype none
// ============================================================================
// Module      : tb_less_than
// Description : Self-checking bench for less_than at WIDTH=32 and WIDTH=8.
//               Expected {lt,ltu,eq} come from the language's signed and
//               unsigned compares and are queued when a vector is driven.
// Revision    : 1.0  initial release
// ============================================================================
module tb_less_than;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] sr32;
    logic [31:0] tg32;
    logic [7:0]  sr8;
    logic [7:0]  tg8;

    logic ov32, lt32, ltu32, eq32;
    logic ov8,  lt8,  ltu8,  eq8;

    int unsigned n_vec;
    int unsigned n_err;

    logic [2:0] q32[$];
    logic [2:0] q8[$];
    logic [2:0] held32;
    logic [2:0] held8;
    logic       pv;

    less_than #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sr(sr32), .tg(tg32),
        .out_valid(ov32), .lt(lt32), .ltu(ltu32), .eq(eq32)
    );

    less_than #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sr(sr8), .tg(tg8),
        .out_valid(ov8), .lt(lt8), .ltu(ltu8), .eq(eq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] model32(input logic [31:0] a, input logic [31:0] b);
        return {$signed(a) < $signed(b), a < b, a == b};
    endfunction

    function automatic logic [2:0] model8(input logic [7:0] a, input logic [7:0] b);
        return {$signed(a) < $signed(b), a < b, a == b};
    endfunction

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare what the DUTs present now against what the previous cycle's
    // stimulus should have produced.
    task automatic check_outputs(input string tag);
        logic [2:0] e;
        if (pv) begin
            e = (q32.size() > 0) ? q32.pop_front() : 3'bxxx;
            held32 = e;
            chk({tag, "/valid32"}, {2'b00, ov32}, 3'b001);
            chk({tag, "/res32"}, {lt32, ltu32, eq32}, e);
            e = (q8.size() > 0) ? q8.pop_front() : 3'bxxx;
            held8 = e;
            chk({tag, "/valid8"}, {2'b00, ov8}, 3'b001);
            chk({tag, "/res8"}, {lt8, ltu8, eq8}, e);
        end else begin
            chk({tag, "/idle32"}, {2'b00, ov32}, 3'b000);
            chk({tag, "/hold32"}, {lt32, ltu32, eq32}, held32);
            chk({tag, "/idle8"}, {2'b00, ov8}, 3'b000);
            chk({tag, "/hold8"}, {lt8, ltu8, eq8}, held8);
        end
    endtask

    // One clock: check the outputs of the previous capture, then drive the
    // next inputs and queue their expected results.
    task automatic step(input string tag, input logic v, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        check_outputs(tag);
        in_valid = v;
        sr32     = a;
        tg32     = b;
        sr8      = a[7:0];
        tg8      = b[7:0];
        if (v) begin
            q32.push_back(model32(a, b));
            q8.push_back(model8(a[7:0], b[7:0]));
        end
        pv = v;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/z32"}, {lt32, ltu32, eq32}, 3'b000);
        chk({tag, "/zv32"}, {2'b00, ov32}, 3'b000);
        chk({tag, "/z8"}, {lt8, ltu8, eq8}, 3'b000);
        chk({tag, "/zv8"}, {2'b00, ov8}, 3'b000);
    endtask

    logic [31:0] va[6];
    logic [31:0] vb[6];

    initial begin
        n_vec    = 0;
        n_err    = 0;
        pv       = 1'b0;
        held32   = 3'b000;
        held8    = 3'b000;
        rst      = 1'b1;
        in_valid = 1'b0;
        sr32     = '0;
        tg32     = '0;
        sr8      = '0;
        tg8      = '0;

        va[0] = 32'd3;          vb[0] = 32'd7;
        va[1] = 32'd8;          vb[1] = 32'd4;
        va[2] = 32'hFFFF_FFFE;  vb[2] = 32'd3;
        va[3] = 32'd2;          vb[3] = 32'hFFFF_FFFD;
        va[4] = 32'hFFFF_FFFF;  vb[4] = 32'd0;
        va[5] = 32'h8000_0000;  vb[5] = 32'h7FFF_FFFF;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Directed: equal operands, then idle with held result
        step("eq_drive", 1'b1, 32'd5, 32'd5);
        step("eq_res",   1'b0, 32'd0, 32'd0);
        step("eq_hold",  1'b0, 32'd9, 32'd1);

        // Directed vectors each followed by an idle cycle
        for (int i = 0; i < 6; i++) begin
            step("dir_drive", 1'b1, va[i], vb[i]);
            step("dir_res",   1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
        end

        // Same six vectors back-to-back, then the equal pair
        for (int i = 0; i < 6; i++)
            step("stream", 1'b1, va[i], vb[i]);
        step("stream", 1'b1, 32'd5, 32'd5);
        step("stream_end", 1'b0, 32'd0, 32'd0);
        step("stream_hold", 1'b0, 32'd0, 32'd0);

        // Reset with results in flight: outputs clear before any clock edge
        step("pre_rst", 1'b1, 32'd3, 32'd7);
        step("pre_rst", 1'b1, 32'd5, 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        @(posedge clk);
        #1;
        check_zero("rst_held");
        rst      = 1'b0;
        in_valid = 1'b0;
        q32.delete();
        q8.delete();
        pv     = 1'b0;
        held32 = 3'b000;
        held8  = 3'b000;
        step("post_rst", 1'b1, 32'hFFFF_FFFF, 32'd0);
        step("post_rst", 1'b0, 32'd0, 32'd0);

        // Random vectors, mostly valid, with some equal and sign-edge operands
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        v;
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 7))
                0: b = a;
                1: begin a[7:0] = b[7:0]; end
                2: begin a = {1'b1, 31'd0}; b = {1'b0, {31{1'b1}}}; end
                default: ;
            endcase
            v = ($urandom_range(0, 9) != 0);
            step("rand", v, a, b);
        end
        step("drain", 1'b0, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_less_than
`default_nettype wire
